pll_lock_sequencer: RTL

- Controller for the PLL reset/lock interface: drives the PLL active-low reset, watches the PLL lock flag, and releases the system reset only once lock is stable.
- Retries on lock timeout and latches a fault after the retry budget is spent.
- Runs on the PLL reference clock and sits beside the PLL wrapper at chip top.
- Re-sequences on lock loss or on a RESTART request.

---
 rtl/pll_lock_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer.
// Holds the PLL in reset, waits for lock, and releases the system reset
// only after lock has stayed high for STABLE_CYCLES. A lock timeout or a
// lock drop during stabilization costs one retry. A lock drop in RUN starts
// a new sequence with a fresh retry budget. When the budget is spent the
// block parks in FAULT until RESTART or RESET.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   HOLD      | PLL_RESETB low, counting HOLD_CYCLES
//   WAIT_LOCK | PLL_RESETB high, waiting up to LOCK_TIMEOUT for lock_s
//   STABILIZE | lock_s seen, requiring STABLE_CYCLES of continuous lock
//   RUN       | system reset released, READY high, watching for lock loss
//   FAULT     | retry budget spent, PLL held in reset, waiting for RESTART
module pll_lock_sequencer #(
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 16000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       RESTART,
  output logic       PLL_RESETB,
  output logic       SYS_RESETN,
  output logic       READY,
  output logic       FAULT,
  output logic       LOCK_LOST,
  output logic [1:0] RETRY_CNT
);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             sync1_q, lock_s_q;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_resetn_q, sys_resetn_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             lock_lost_q, lock_lost_d;
  logic             fail_attempt;

  // Two-flop synchronizer for the asynchronous PLL lock flag.
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= PLL_LOCK;
      lock_s_q <= sync1_q;
    end
  end

  // State, counter, retry and registered outputs.
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      retry_q      <= 2'd0;
      pll_resetb_q <= 1'b0;
      sys_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_resetb_q <= pll_resetb_d;
      sys_resetn_q <= sys_resetn_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  // Next-state decode; outputs derive from the next state so they move with it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    lock_lost_d  = 1'b0;
    fail_attempt = 1'b0;

    if (RESTART) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      retry_d = 2'd0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          // Lock wins over a timeout landing on the same cycle.
          if (lock_s_q) begin
            state_d = S_STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            fail_attempt = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STABILIZE: begin
          if (!lock_s_q) begin
            fail_attempt = 1'b1;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d     = S_HOLD;
            cnt_d       = '0;
            retry_d     = 2'd0;
            lock_lost_d = 1'b1;
          end
        end
        S_FAULT: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      endcase

      if (fail_attempt) begin
        cnt_d = '0;
        if (retry_q == RETRY_MAX) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_HOLD;
          retry_d = retry_q + 2'd1;
        end
      end
    end

    pll_resetb_d = (state_d == S_WAIT_LOCK) || (state_d == S_STABILIZE) || (state_d == S_RUN);
    sys_resetn_d = (state_d == S_RUN);
    ready_d      = (state_d == S_RUN);
    fault_d      = (state_d == S_FAULT);
  end

  assign PLL_RESETB = pll_resetb_q;
  assign SYS_RESETN = sys_resetn_q;
  assign READY      = ready_q;
  assign FAULT      = fault_q;
  assign LOCK_LOST  = lock_lost_q;
  assign RETRY_CNT  = retry_q;

endmodule
